// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit. It holds the program counter and fetches
//            one 32-bit word from instruction memory over a req/valid
//            handshake. It presents the word to the IDU with Fetch_ready, then
//            waits for decode (IDU_ready) and CU retirement (cu_done). After
//            that it advances the PC by the decoded increment or by a CU
//            redirect.
// Ports    : soc_clk, reset (async, active-low)
//            mem_req/mem_addr/mem_rdata/mem_valid   - instruction memory
//            instruction/Fetch_ready/pc             - to the IDU
//            IDU_ready/pc_increment/invalid_instruction - from the IDU
//            cu_done/redirect_valid/redirect_pc     - from the CU
//            halted/error_code                      - status
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        soc_clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  output logic [31:0] pc,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        invalid_instruction,
  input  logic        cu_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [1:0]  error_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_MISALGN = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  // Last WAIT cycle that may still accept data. If no mem_valid arrives in
  // that cycle, the count would reach MEM_TIMEOUT and the fetch is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] inc_q, inc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic        mem_req_q;
  logic        fetch_ready_q;
  logic        halted_q;

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        cnt_d = 8'd0;
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
          err_d   = ERR_MISALGN;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Data wins over the timeout in the same cycle.
        if (mem_valid) begin
          instr_d = mem_rdata;
          state_d = S_PRESENT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_PRESENT: begin
        if (IDU_ready) begin
          if (invalid_instruction) begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end else begin
            inc_d   = pc_increment;
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (cu_done) begin
          // Bit 0 of a redirect target is always cleared. Bit 1 is kept, so a
          // half-word target is caught as misaligned in the next FETCH.
          if (redirect_valid) pc_d = redirect_pc & ~32'h1;
          else                pc_d = pc_q + inc_q;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. The outputs are decoded from the next
  // state, so they line up with the state that the register is entering.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      inc_q         <= 32'd4;
      cnt_q         <= 8'd0;
      err_q         <= ERR_NONE;
      mem_req_q     <= 1'b0;
      fetch_ready_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      inc_q         <= inc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      mem_req_q     <= (state_d == S_FETCH) || (state_d == S_WAIT);
      fetch_ready_q <= (state_d == S_PRESENT) || (state_d == S_EXEC);
      halted_q      <= (state_d == S_HALT);
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign Fetch_ready = fetch_ready_q;
  assign halted      = halted_q;
  assign error_code  = err_q;

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that supplies the IDU with one instruction at a time. It holds the program counter, fetches a 32-bit word from instruction memory over a req/valid handshake, and presents the word to the IDU with a `Fetch_ready` level that rises once per instruction. It waits for `IDU_ready` and then for CU retirement, and advances the PC by the decoded `pc_increment` or by a CU redirect. It sits between instruction memory and `IDU_top`, on the opposite side of the `instruction`/`Fetch_ready` ↔ `IDU_ready` interface.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MEM_TIMEOUT`, 15, maximum cycles in WAIT before a timeout error (range 1–255).
- `soc_clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  word address, equal to `pc`.
- `mem_rdata`  in  32  memory read data.
- `mem_valid`  in  1  `mem_rdata` valid this cycle.
- `instruction`  out  32  held fetched word, to the IDU.
- `Fetch_ready`  out  1  instruction valid; held high until retirement.
- `pc`  out  32  address of the current instruction.
- `IDU_ready`  in  1  decode complete.
- `pc_increment`  in  32  from the IDU; signed PC offset.
- `invalid_instruction`  in  1  from the IDU.
- `cu_done`  in  1  CU has retired the current instruction (single-cycle pulse).
- `redirect_valid`  in  1  CU redirect; sampled only with `cu_done`.
- `redirect_pc`  in  32  redirect target.
- `halted`  out  1  unit stopped; cleared only by reset.
- `error_code`  out  2  00 none, 01 memory timeout, 10 misaligned PC, 11 illegal instruction.

## Operation
States: IDLE, FETCH, WAIT, PRESENT, EXEC, HALT.

- IDLE: entered on reset. Next cycle → FETCH.
- FETCH:
  - `mem_req`=1, `mem_addr`=`pc`, `Fetch_ready`=0.
  - If `pc[1:0]`≠0: → HALT with `error_code`=10.
  - Otherwise → WAIT. The timeout counter is cleared.
- WAIT:
  - `mem_req` stays 1 until `mem_valid`.
  - On `mem_valid`: `instruction`←`mem_rdata`, → PRESENT.
  - Otherwise the counter increments. When the counter reaches `MEM_TIMEOUT` without `mem_valid`: → HALT with `error_code`=01.
  - `mem_valid` in the same cycle the counter would expire: data is accepted, no error.
- PRESENT:
  - `Fetch_ready`=1; `instruction` is stable.
  - On `IDU_ready`=1:
    - if `invalid_instruction`=1: → HALT with `error_code`=11;
    - else latch `inc_q`←`pc_increment` and → EXEC.
- EXEC:
  - `Fetch_ready` stays 1.
  - On `cu_done`:
    - if `redirect_valid`: `pc`←{`redirect_pc`[31:1],1'b0};
    - else `pc`←`pc`+`inc_q`, modulo 2^32 (wraps, no error).
    - Then → FETCH.
- HALT:
  - `halted`=1, `mem_req`=0, `Fetch_ready`=0.
  - `error_code` is held; all inputs are ignored.
- Ignored inputs:
  - `cu_done` outside EXEC is ignored.
  - `mem_valid` outside WAIT is ignored.
  - `IDU_ready` outside PRESENT is ignored.
- Alignment: a misaligned target (from increment or redirect) is detected in the following FETCH, not at the update.

## Timing
- Reset values while `reset`=0, asynchronous:
  - state IDLE, `pc`=`RESET_PC`;
  - `mem_req`=0, `mem_addr`=`RESET_PC`;
  - `instruction`=0, `Fetch_ready`=0, `halted`=0, `error_code`=00;
  - `inc_q`=4, timeout counter=0.
- Reset asserted mid-transaction abandons the transaction immediately. A `mem_valid` arriving afterwards is ignored.
- First `mem_req` rises 2 cycles after `reset` deasserts (IDLE, then FETCH).
- `mem_valid` in cycle N → `instruction` updated and `Fetch_ready`=1 from cycle N+1.
- `cu_done` in cycle M → new `pc` and `mem_req`=1 in cycle M+1.
- Best-case instruction period: 4 cycles plus IDU and CU latency.
- `Fetch_ready` is low for at least one full cycle (FETCH) between instructions. This gives the IDU a falling edge, then a rising edge, per instruction.
- All outputs are registered.

## Test plan
- Reset, `RESET_PC`=0x100, `mem_valid` 1 cycle after `mem_req`:
  - `mem_addr`=0x100;
  - `Fetch_ready` rises one cycle after `mem_valid`, with `instruction`=`mem_rdata`=0x00500093.
- Sequential: `IDU_ready`, `pc_increment`=4, `cu_done`, no redirect → next `mem_addr`=0x104. `Fetch_ready` is low for ≥1 cycle between instructions.
- JAL and redirect:
  - `pc_increment`=0xFFFF_FFF8 at `pc`=0x104 → next `pc`=0xFC.
  - `cu_done` with `redirect_valid`=1 and `redirect_pc`=0x201 → `pc`=0x200. `redirect_pc`=0x202 instead → HALT with `error_code`=10.
  - `pc`=0xFFFF_FFFC with `pc_increment`=4 → `pc`=0x0, no error.
- Memory stall and timeout, `MEM_TIMEOUT`=15:
  - `mem_valid` after 14 cycles → accepted;
  - `mem_valid` on the expiry cycle → accepted, no error;
  - no `mem_valid` → `halted`=1, `error_code`=01, `mem_req`=0.
- Error and reset recovery:
  - `invalid_instruction`=1 with `IDU_ready` → `halted`=1, `error_code`=11;
  - a subsequent `cu_done` has no effect;
  - async `reset` low mid-WAIT → all outputs at reset values within the same cycle, and fetch restarts at `RESET_PC` after release.
